// File: rtl/line_buffer_ctrl_if.sv
// Capture/line-RAM side signal bundle for line_buffer_ctrl; master = capture/RAM side, slave = controller.
// LAST_LEN is present only when LINE_STATS_EN is defined.
interface line_buffer_ctrl_if #(
    parameter int ADDR_W = 13,
    parameter int LINE_W = 12
);
    logic              mCCD_FVAL;
    logic              mCCD_LVAL;
    logic [ADDR_W-1:0] X_Cont;
    logic [2:0]        WR_EN;
    logic [1:0]        TAP_SEL;
    logic [ADDR_W-1:0] READ_Cont;
    logic              READ_Request;
    logic [LINE_W-1:0] LINE_Cont;
    logic              LINE_OVF;
    logic              FRAME_DONE;
`ifdef LINE_STATS_EN
    logic [ADDR_W:0]   LAST_LEN;

    modport master (
        output mCCD_FVAL, mCCD_LVAL,
        input  X_Cont, WR_EN, TAP_SEL, READ_Cont, READ_Request,
               LINE_Cont, LINE_OVF, FRAME_DONE, LAST_LEN
    );
    modport slave (
        input  mCCD_FVAL, mCCD_LVAL,
        output X_Cont, WR_EN, TAP_SEL, READ_Cont, READ_Request,
               LINE_Cont, LINE_OVF, FRAME_DONE, LAST_LEN
    );
`else
    modport master (
        output mCCD_FVAL, mCCD_LVAL,
        input  X_Cont, WR_EN, TAP_SEL, READ_Cont, READ_Request,
               LINE_Cont, LINE_OVF, FRAME_DONE
    );
    modport slave (
        input  mCCD_FVAL, mCCD_LVAL,
        output X_Cont, WR_EN, TAP_SEL, READ_Cont, READ_Request,
               LINE_Cont, LINE_OVF, FRAME_DONE
    );
`endif
endinterface

// File: rtl/line_buffer_ctrl.sv
// Sequencer for the 3-bank rotating Sobel line buffer, driven by camera FVAL/LVAL.
// Optional per-line pixel count output LAST_LEN is enabled by defining LINE_STATS_EN.
module line_buffer_ctrl #(
    parameter int LINE_WIDTH = 640,
    parameter int ADDR_W     = 13,
    parameter int LINE_W     = 12
) (
    input  logic               CCD_PIXCLK,
    input  logic               RESET,
    line_buffer_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_LINE, S_LINE, S_BLANK} state_t;

    localparam logic [ADDR_W-1:0] X_LIMIT = ADDR_W'(LINE_WIDTH);

    state_t            state;
    logic              f_q, f_d, l_q, l_d;
    logic              f_rise, f_fall, l_rise;
    logic              frame_start, line_end, pixel_in;
    logic [1:0]        bank, bank_next;
    logic [ADDR_W-1:0] x_cnt, x_cont;
    logic [2:0]        wr_en;
    logic [LINE_W-1:0] line_cnt, line_cnt_next;
    logic              line_ovf, frame_done;

    // FVAL history resets high so a frame already in progress at reset release never looks like a rise.
    always_ff @(posedge CCD_PIXCLK or posedge RESET) begin
        if (RESET) begin
            f_q <= 1'b1;
            f_d <= 1'b1;
            l_q <= 1'b0;
            l_d <= 1'b0;
        end else begin
            f_q <= bus.mCCD_FVAL;
            f_d <= f_q;
            l_q <= bus.mCCD_LVAL;
            l_d <= l_q;
        end
    end

    assign f_rise        = f_q & ~f_d;
    assign f_fall        = ~f_q & f_d;
    assign l_rise        = l_q & ~l_d;
    assign frame_start   = (state == S_IDLE) & f_rise;
    assign line_end      = (state == S_LINE) & (~l_q | f_fall);
    assign pixel_in      = l_q & ~f_fall &
                           ((state == S_LINE) | (((state == S_WAIT_LINE) | (state == S_BLANK)) & l_rise));
    assign bank_next     = (bank == 2'd2) ? 2'd0 : bank + 2'd1;
    assign line_cnt_next = (&line_cnt) ? line_cnt : line_cnt + LINE_W'(1);

    // The rising-edge pixel is written immediately so WR_EN trails LVAL by exactly two cycles.
    always_ff @(posedge CCD_PIXCLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            bank       <= 2'd0;
            x_cnt      <= '0;
            x_cont     <= '0;
            wr_en      <= 3'b000;
            line_cnt   <= '0;
            line_ovf   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= 3'b000;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (f_rise) begin
                        state    <= S_WAIT_LINE;
                        bank     <= 2'd0;
                        line_cnt <= '0;
                        line_ovf <= 1'b0;
                        x_cnt    <= '0;
                    end
                end
                S_WAIT_LINE, S_BLANK: begin
                    if (f_fall) begin
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                    end else if (l_rise) begin
                        state  <= S_LINE;
                        wr_en  <= 3'b001 << bank;
                        x_cont <= '0;
                        x_cnt  <= ADDR_W'(1);
                    end
                end
                S_LINE: begin
                    if (line_end) begin
                        bank     <= bank_next;
                        line_cnt <= line_cnt_next;
                        x_cnt    <= '0;
                    end else if (x_cnt == X_LIMIT) begin
                        line_ovf <= 1'b1;
                    end else begin
                        wr_en  <= 3'b001 << bank;
                        x_cont <= x_cnt;
                        x_cnt  <= x_cnt + ADDR_W'(1);
                    end
                    if (f_fall) begin
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                    end else if (!l_q) begin
                        state <= S_BLANK;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.X_Cont       = x_cont;
    assign bus.READ_Cont    = x_cont;
    assign bus.WR_EN        = wr_en;
    assign bus.TAP_SEL      = bank;
    assign bus.LINE_Cont    = line_cnt;
    assign bus.LINE_OVF     = line_ovf;
    assign bus.FRAME_DONE   = frame_done;
    assign bus.READ_Request = (|wr_en) & (line_cnt >= LINE_W'(2));

`ifdef LINE_STATS_EN
    logic [ADDR_W:0] len_cnt, last_len;

    // Counts every LVAL pixel of the line, including ones dropped after overflow or cut by FVAL.
    always_ff @(posedge CCD_PIXCLK or posedge RESET) begin
        if (RESET) begin
            len_cnt  <= '0;
            last_len <= '0;
        end else if (frame_start) begin
            len_cnt  <= '0;
            last_len <= '0;
        end else if (line_end) begin
            last_len <= len_cnt + {{ADDR_W{1'b0}}, l_q};
            len_cnt  <= '0;
        end else if (pixel_in) begin
            len_cnt <= len_cnt + (ADDR_W + 1)'(1);
        end
    end

    assign bus.LAST_LEN = last_len;
`endif
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl with LINE_WIDTH=8; LAST_LEN checks apply when LINE_STATS_EN is defined.
module tb_line_buffer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    line_buffer_ctrl_if #(.ADDR_W(13), .LINE_W(12)) bus ();

    line_buffer_ctrl #(.LINE_WIDTH(8), .ADDR_W(13), .LINE_W(12)) dut (
        .CCD_PIXCLK (clk),
        .RESET      (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        f;
        logic        l;
        logic [2:0]  wr;
        logic [12:0] x;
        logic        req;
        logic [1:0]  tap;
        logic [11:0] line;
        logic        ovf;
        logic        done;
    } vec_t;

    typedef struct {
        logic [2:0]  wr;
        logic [12:0] x;
        logic [12:0] rc;
        logic        req;
        logic [1:0]  tap;
    } wr_rec_t;

    vec_t    vecs[22];
    wr_rec_t mon_q[$];
    int      mon_done = 0;
    logic    mon_on = 1'b0;
    int      frame_lens[$];
    int      n_vec = 0;
    int      n_bad = 0;
    int      w_cnt, d_cnt, post_done_w;
    logic [12:0] x_max;

    // Write-side observer used by the frame-level model comparison.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.WR_EN != 3'b000)
                mon_q.push_back('{bus.WR_EN, bus.X_Cont, bus.READ_Cont, bus.READ_Request, bus.TAP_SEL});
            if (bus.FRAME_DONE) mon_done++;
        end
    end

    function automatic vec_t mk(int f, int l, int wr, int x, int req, int tap, int line, int ovf, int done);
        vec_t v;
        v.f = 1'(f); v.l = 1'(l); v.wr = 3'(wr); v.x = 13'(x); v.req = 1'(req);
        v.tap = 2'(tap); v.line = 12'(line); v.ovf = 1'(ovf); v.done = 1'(done);
        return v;
    endfunction

    function automatic logic [63:0] pack_rec(wr_rec_t r);
        return 64'({r.wr, r.x, r.rc, r.req, r.tap});
    endfunction

    function automatic logic [63:0] pack_all();
        return 64'({bus.WR_EN, bus.X_Cont, bus.READ_Cont, bus.READ_Request, bus.TAP_SEL,
                    bus.LINE_Cont, bus.LINE_OVF, bus.FRAME_DONE});
    endfunction

    task automatic applyStimulus(input logic f, input logic l);
        bus.mCCD_FVAL = f;
        bus.mCCD_LVAL = l;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic clear_counts();
        w_cnt = 0; d_cnt = 0; post_done_w = 0; x_max = '0;
    endtask

    task automatic step_count(input logic f, input logic l, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(f, l);
            if (bus.WR_EN != 3'b000) begin
                w_cnt++;
                if (bus.X_Cont > x_max) x_max = bus.X_Cont;
                if (d_cnt > 0) post_done_w++;
            end
            if (bus.FRAME_DONE) d_cnt++;
        end
    endtask

    // Frame-level model: line i goes to bank i%3, stores min(len,8) pixels, taps valid from the third line.
    task automatic run_frame(input string tag);
        wr_rec_t exp_q[$];
        int base_w, base_d, nw, nl, ovf_any, got_n;
        base_w  = mon_q.size();
        base_d  = mon_done;
        nl      = frame_lens.size();
        ovf_any = 0;
        mon_on  = 1'b1;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        repeat ($urandom_range(1, 3)) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < nl; i++) begin
            repeat (frame_lens[i]) applyStimulus(1'b1, 1'b1);
            repeat ($urandom_range(1, 3)) applyStimulus(1'b1, 1'b0);
            nw = (frame_lens[i] > 8) ? 8 : frame_lens[i];
            if (frame_lens[i] > 8) ovf_any = 1;
            for (int p = 0; p < nw; p++)
                exp_q.push_back('{3'(1 << (i % 3)), 13'(p), 13'(p), (i >= 2), 2'(i % 3)});
        end
        repeat (4) applyStimulus(1'b0, 1'b0);
        mon_on = 1'b0;
        got_n = mon_q.size() - base_w;
        checkOutput({tag, "_writes"}, 64'(got_n), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_n; k++)
            checkOutput({tag, "_pix"}, pack_rec(mon_q[base_w + k]), pack_rec(exp_q[k]));
        checkOutput({tag, "_line_cont"}, 64'(bus.LINE_Cont), 64'(nl));
        checkOutput({tag, "_tap_sel"}, 64'(bus.TAP_SEL), 64'(nl % 3));
        checkOutput({tag, "_ovf"}, 64'(bus.LINE_OVF), 64'(ovf_any));
        checkOutput({tag, "_done_cnt"}, 64'(mon_done - base_d), 64'd1);
`ifdef LINE_STATS_EN
        checkOutput({tag, "_last_len"}, 64'(bus.LAST_LEN), 64'(frame_lens[nl - 1]));
`endif
    endtask

    initial begin
        logic [63:0] got_v, want_v;
        bus.mCCD_FVAL = 1'b0;
        bus.mCCD_LVAL = 1'b0;

        for (int i = 0; i < 22; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 4; i <= 10; i++) vecs[i] = mk(1, 1, 1, i - 4, 0, 0, 0, 0, 0);
        vecs[11] = mk(1, 0, 1, 7, 0, 0, 0, 0, 0);
        vecs[12] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[13] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[15] = mk(0, 1, 0, 0, 0, 1, 1, 0, 1);
        vecs[16] = mk(0, 1, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 17; i < 22; i++) vecs[i] = mk(0, (i == 18) ? 1 : 0, 0, 0, 0, 1, 1, 0, 0);

        #2;
        checkOutput("reset_outputs", pack_all(), 64'd0);
`ifdef LINE_STATS_EN
        checkOutput("reset_last_len", 64'(bus.LAST_LEN), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] single line then LVAL pulses with FVAL low");
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].f, vecs[i].l);
            got_v  = 64'({bus.WR_EN, (vecs[i].wr != 0) ? bus.X_Cont : 13'd0, bus.READ_Request,
                          bus.TAP_SEL, bus.LINE_Cont, bus.LINE_OVF, bus.FRAME_DONE});
            want_v = 64'({vecs[i].wr, vecs[i].x, vecs[i].req, vecs[i].tap, vecs[i].line,
                          vecs[i].ovf, vecs[i].done});
            checkOutput($sformatf("vec%0d", i), got_v, want_v);
        end

        $display("[TB] overflow line");
        clear_counts();
        step_count(1'b0, 1'b0, 2);
        step_count(1'b1, 1'b0, 2);
        step_count(1'b1, 1'b1, 11);
        checkOutput("ovf_hold", 64'({bus.WR_EN, bus.X_Cont, bus.LINE_OVF}), 64'({3'b000, 13'd7, 1'b1}));
        step_count(1'b1, 1'b0, 2);
        checkOutput("ovf_writes", 64'(w_cnt), 64'd8);
        checkOutput("ovf_x_max", 64'(x_max), 64'd7);
        checkOutput("ovf_line_cont", 64'({bus.LINE_Cont, bus.LINE_OVF}), 64'({12'd1, 1'b1}));
`ifdef LINE_STATS_EN
        checkOutput("ovf_last_len", 64'(bus.LAST_LEN), 64'd11);
`endif
        step_count(1'b1, 1'b1, 4);
        step_count(1'b1, 1'b0, 2);
        checkOutput("ovf_sticky", 64'({bus.LINE_Cont, bus.LINE_OVF}), 64'({12'd2, 1'b1}));
`ifdef LINE_STATS_EN
        checkOutput("short_last_len", 64'(bus.LAST_LEN), 64'd4);
`endif
        step_count(1'b0, 1'b0, 3);
        checkOutput("ovf_after_frame", 64'({bus.LINE_OVF, 8'(d_cnt)}), 64'({1'b1, 8'd1}));
        step_count(1'b1, 1'b0, 3);
        checkOutput("ovf_cleared", 64'(bus.LINE_OVF), 64'd0);

        $display("[TB] FVAL drop mid-line");
        clear_counts();
        step_count(1'b1, 1'b1, 8);
        step_count(1'b1, 1'b0, 2);
        step_count(1'b1, 1'b1, 3);
        step_count(1'b0, 1'b1, 3);
        step_count(1'b0, 1'b0, 4);
        checkOutput("cut_writes", 64'(w_cnt), 64'd11);
        checkOutput("cut_done_cycles", 64'(d_cnt), 64'd1);
        checkOutput("cut_post_done_wr", 64'(post_done_w), 64'd0);
        checkOutput("cut_line_tap", 64'({bus.LINE_Cont, bus.TAP_SEL}), 64'({12'd2, 2'd2}));
        step_count(1'b1, 1'b0, 3);
        checkOutput("next_frame_start", 64'({bus.LINE_Cont, bus.TAP_SEL}), 64'({12'd0, 2'd0}));

        $display("[TB] reset mid-line with FVAL high");
        clear_counts();
        step_count(1'b0, 1'b0, 2);
        step_count(1'b1, 1'b0, 2);
        step_count(1'b1, 1'b1, 3);
        checkOutput("pre_reset_wr", 64'(bus.WR_EN), 64'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_reset", pack_all(), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_counts();
        step_count(1'b1, 1'b1, 2);
        step_count(1'b1, 1'b0, 2);
        step_count(1'b1, 1'b1, 4);
        step_count(1'b1, 1'b0, 3);
        checkOutput("no_partial_frame", 64'({8'(w_cnt), bus.LINE_Cont}), 64'({8'd0, 12'd0}));
        clear_counts();
        step_count(1'b0, 1'b0, 2);
        step_count(1'b1, 1'b0, 2);
        step_count(1'b1, 1'b1, 4);
        step_count(1'b1, 1'b0, 2);
        checkOutput("fresh_frame", 64'({8'(w_cnt), bus.LINE_Cont}), 64'({8'd4, 12'd1}));
        step_count(1'b0, 1'b0, 4);

        $display("[TB] four full lines, then random frames");
        frame_lens = {8, 8, 8, 8};
        run_frame("four_lines");
        for (int fr = 0; fr < 6; fr++) begin
            frame_lens = {};
            repeat ($urandom_range(1, 6)) frame_lens.push_back($urandom_range(1, 11));
            run_frame($sformatf("rand%0d", fr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Single-clock sequencer for the 3-bank rotating line buffer in the Sobel path.
- Generates the write address, one-hot bank write enables and the read address from the camera's frame-valid and line-valid qualifiers.
- Generates the tap-rotation select and the read request, which is gated until two full lines are buffered.
- Sits between the D8M capture front-end and the three dual-port line RAMs.
- Detects line ends synchronously, so no logic is clocked on a line-valid edge.

Parameters:
LINE_WIDTH, 640, max pixels stored per line (RAM depth used)
ADDR_W, 13, width of X_Cont/READ_Cont
LINE_W, 12, width of LINE_Cont

Ports:
CCD_PIXCLK  in  1  pixel clock; all logic on rising edge
RESET  in  1  asynchronous, active-high reset
mCCD_FVAL  in  1  frame valid from capture
mCCD_LVAL  in  1  line valid from capture
X_Cont  out  ADDR_W  write address into the active bank
WR_EN  out  3  one-hot write enable, bit n = bank n
TAP_SEL  out  2  index of the bank currently being written (0..2)
READ_Cont  out  ADDR_W  read address for the two non-written banks
READ_Request  out  1  tap outputs are valid this cycle
LINE_Cont  out  LINE_W  completed lines in the current frame, saturating
LINE_OVF  out  1  sticky per frame: a line exceeded LINE_WIDTH
FRAME_DONE  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, active-high): all outputs 0, internal bank index 0, state S_IDLE.
- Sampling and edges:
  - mCCD_FVAL/mCCD_LVAL are registered once (f_q, l_q).
  - Edges are computed from f_q/l_q against their previous values.
- States:
  - S_IDLE: waits for an f_q rise. Entering S_WAIT_LINE sets bank=0, LINE_Cont=0, LINE_OVF=0.
  - S_WAIT_LINE: waits for an l_q rise, then goes to S_LINE with X counter=0.
  - S_LINE: while l_q=1, writes one pixel per cycle. On an l_q fall, performs line end and goes to S_BLANK.
  - S_BLANK: on an l_q rise, goes to S_LINE.
  - Any state except S_IDLE: an f_q fall goes to S_IDLE and pulses FRAME_DONE for 1 cycle.
- Pixel-write outputs:
  - Registered. In a cycle where l_q=1 in S_LINE, next cycle WR_EN = 1<<bank and X_Cont = counter, and the counter increments.
  - Total latency is 2 cycles from mCCD_LVAL to WR_EN; the capture data path must delay mCCD_DATA by 2 cycles to match.
- Read outputs:
  - READ_Cont equals X_Cont in the same cycle.
  - READ_Request = (WR_EN!=0) & (LINE_Cont>=2).
  - TAP_SEL = bank.
  - Consumer rule: tap0 = bank (TAP_SEL+1) mod 3, tap1 = bank (TAP_SEL+2) mod 3.
- Line end:
  - Bank advances 0→1→2→0.
  - LINE_Cont increments, saturating at all-ones.
  - Counter clears to 0.
  - WR_EN is 0 from the cycle after the last pixel.
- Overflow:
  - Triggered when the counter reaches LINE_WIDTH with l_q still 1.
  - WR_EN is forced to 0 for the rest of the line, X_Cont holds at LINE_WIDTH-1, and LINE_OVF is set.
  - The line still completes normally on the l_q fall.
- f_q fall while l_q=1: treated as a line end first (bank/LINE_Cont update), then FRAME_DONE and S_IDLE, all in the same cycle.
- l_q=1 while f_q=0: ignored; no writes.
- Reset deasserted with mCCD_FVAL already high: stays in S_IDLE until a fresh FVAL rise, so no partial frames are accepted.
- Simultaneous l_q rise and f_q rise: the frame starts, and the line is accepted only from the next l_q rise.

Optional Feature:
LINE_STATS_EN
- Defined:
  - Adds output LAST_LEN [ADDR_W:0].
  - Loaded at every line end with the number of pixels asserted on LVAL in that line, including pixels dropped by overflow.
  - Reset value 0; cleared at frame start.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
Bench uses LINE_WIDTH=8.
1. Reset then FVAL rise, LVAL high 8 cycles → WR_EN=3'b001 for exactly 8 cycles, X_Cont 0..7, READ_Request=0, and after the line LINE_Cont=1, TAP_SEL=1.
2. Four 8-pixel lines in one frame → WR_EN walks 001,010,100,001; READ_Request is 0 during lines 1–2 and high for all 8 pixels of lines 3 and 4; TAP_SEL during line 3 is 2.
3. Line with LVAL high 11 cycles → 8 writes, X_Cont holds at 7, LINE_OVF=1 until the next FVAL rise; LAST_LEN=11 when LINE_STATS_EN is defined.
4. FVAL falls while LVAL is high mid-line → FRAME_DONE pulses for exactly 1 cycle, LINE_Cont increments, no further WR_EN; the next frame starts with TAP_SEL=0 and LINE_Cont=0.
5. RESET asserted mid-line with FVAL held high → outputs go to 0 immediately; after release, LVAL pulses produce no writes until FVAL toggles low then high.
6. LVAL pulses with FVAL=0 → WR_EN stays 0, LINE_Cont unchanged, no FRAME_DONE.
